// File: rtl/npn_canon_seq_if.sv
// Handshake and result bus of the NPN canonicaliser.
// The master drives requests and accepts results; the slave is the canonicaliser.
interface npn_canon_seq_if #(
  parameter int NUM_INPUTS = 4
);
  localparam int TT_W = 2**NUM_INPUTS;
  localparam int PW   = ($clog2(NUM_INPUTS) < 1) ? 1 : $clog2(NUM_INPUTS);

  logic                       in_valid;
  logic                       in_ready;
  logic [TT_W-1:0]            in_tt;
  logic                       out_valid;
  logic                       out_ready;
  logic [TT_W-1:0]            out_tt;
  logic [NUM_INPUTS-1:0]      out_phase;
  logic [NUM_INPUTS*PW-1:0]   out_perm;
  logic                       out_neg;

  modport master (
    output in_valid, in_tt, out_ready,
    input  in_ready, out_valid, out_tt, out_phase, out_perm, out_neg
  );

  modport slave (
    input  in_valid, in_tt, out_ready,
    output in_ready, out_valid, out_tt, out_phase, out_perm, out_neg
  );
endinterface

// File: rtl/npn_canon_seq.sv
// Sequential NPN canonicaliser: walks every (perm, phase[, neg]) transform of a truth table
// and keeps the smallest result. Define NPN_OUT_NEG_EN to include output negation (full NPN).
module npn_canon_seq #(
  parameter int NUM_INPUTS = 4
) (
  input  logic              clk,
  input  logic              rst,
  npn_canon_seq_if.slave    io_bus
);
  localparam int TT_W = 2**NUM_INPUTS;
  localparam int PW   = ($clog2(NUM_INPUTS) < 1) ? 1 : $clog2(NUM_INPUTS);

  function automatic int factorial(input int n);
    int acc;
    acc = 1;
    for (int k = 2; k <= n; k++) acc = acc * k;
    return acc;
  endfunction

  localparam int TOTAL = factorial(NUM_INPUTS) * (2**NUM_INPUTS);
  // 12 bits covers the 5-input worst case (3840 candidates plus the drain cycle).
  localparam int CNT_W = 12;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // g[m] = f[z], z_j = m[perm[j]] ^ phase[j]
  function automatic logic [TT_W-1:0] apply_xform(
    input logic [TT_W-1:0]       f,
    input logic [PW-1:0]         perm [NUM_INPUTS],
    input logic [NUM_INPUTS-1:0] phase
  );
    logic [TT_W-1:0]       g;
    logic [NUM_INPUTS-1:0] x;
    logic [NUM_INPUTS-1:0] z;
    g = '0;
    for (int m = 0; m < TT_W; m++) begin
      x = NUM_INPUTS'(m);
      z = '0;
      for (int j = 0; j < NUM_INPUTS; j++) z[j] = x[perm[j]] ^ phase[j];
      g[m] = f[z];
    end
    return g;
  endfunction

  state_t                     r_state;
  state_t                     w_state_nx;
  logic                       w_accept;
  logic                       w_issue;
  logic                       w_in_ready;
  logic                       w_out_valid;

  logic [CNT_W-1:0]           r_cnt;
  logic [TT_W-1:0]            r_tt;
  logic [NUM_INPUTS-1:0]      r_phase;
  logic [PW-1:0]              r_perm   [NUM_INPUTS];
  logic [PW-1:0]              r_c      [NUM_INPUTS];
  logic [PW-1:0]              w_perm_nx [NUM_INPUTS];
  logic [PW-1:0]              w_c_nx    [NUM_INPUTS];
  logic                       w_found;

  logic [TT_W-1:0]            w_cand_p0;
  logic [TT_W-1:0]            r_cand_p1;
  logic [NUM_INPUTS-1:0]      r_phase_p1;
  logic [PW-1:0]              r_perm_p1 [NUM_INPUTS];
  logic                       r_vld_p1;

  logic                       w_win;
  logic [TT_W-1:0]            w_win_tt;
  logic [TT_W-1:0]            r_best_tt;
  logic [NUM_INPUTS-1:0]      r_best_phase;
  logic [PW-1:0]              r_best_perm [NUM_INPUTS];
  logic [NUM_INPUTS*PW-1:0]   w_out_perm;
`ifdef NPN_OUT_NEG_EN
  logic                       w_win_neg;
  logic                       r_best_neg;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // RUN spends TOTAL cycles issuing candidates plus one to drain the compare stage.
  always_comb begin
    w_state_nx  = r_state;
    w_accept    = 1'b0;
    w_issue     = 1'b0;
    w_in_ready  = 1'b0;
    w_out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_in_ready = 1'b1;
        if (io_bus.in_valid) begin
          w_accept   = 1'b1;
          w_state_nx = S_RUN;
        end
      end
      S_RUN: begin
        if (r_cnt < CNT_W'(TOTAL)) w_issue    = 1'b1;
        else                       w_state_nx = S_DONE;
      end
      S_DONE: begin
        w_out_valid = 1'b1;
        if (io_bus.out_ready) w_state_nx = S_IDLE;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Heap's algorithm, one permutation step per call: the lowest i with c[i] < i swaps.
  always_comb begin
    w_perm_nx = r_perm;
    w_c_nx    = r_c;
    w_found   = 1'b0;
    for (int i = 1; i < NUM_INPUTS; i++) begin
      if (!w_found) begin
        if (r_c[i] < PW'(i)) begin
          w_found = 1'b1;
          if (i % 2 == 0) begin
            w_perm_nx[0] = r_perm[i];
            w_perm_nx[i] = r_perm[0];
          end else begin
            w_perm_nx[r_c[i]] = r_perm[i];
            w_perm_nx[i]      = r_perm[r_c[i]];
          end
          w_c_nx[i] = r_c[i] + 1'b1;
        end else begin
          w_c_nx[i] = '0;
        end
      end
    end
  end

  // Stage p0: candidate truth table for the current (perm, phase)
  assign w_cand_p0 = apply_xform(r_tt, r_perm, r_phase);

  always_ff @(posedge clk) begin
    if (w_accept) r_tt <= io_bus.in_tt;
    r_cand_p1  <= w_cand_p0;
    r_phase_p1 <= r_phase;
    r_perm_p1  <= r_perm;
  end

  // Stage p1: compare plain candidate first, then its complement; strictly-less keeps first minimum
  always_comb begin
    w_win    = 1'b0;
    w_win_tt = r_best_tt;
    if (r_cand_p1 < r_best_tt) begin
      w_win    = 1'b1;
      w_win_tt = r_cand_p1;
    end
`ifdef NPN_OUT_NEG_EN
    w_win_neg = 1'b0;
    if (~r_cand_p1 < w_win_tt) begin
      w_win     = 1'b1;
      w_win_tt  = ~r_cand_p1;
      w_win_neg = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt        <= '0;
      r_phase      <= '0;
      r_vld_p1     <= 1'b0;
      r_best_tt    <= '0;
      r_best_phase <= '0;
      for (int j = 0; j < NUM_INPUTS; j++) begin
        r_perm[j]      <= PW'(j);
        r_c[j]         <= '0;
        r_best_perm[j] <= PW'(j);
      end
`ifdef NPN_OUT_NEG_EN
      r_best_neg   <= 1'b0;
`endif
    end else begin
      r_vld_p1 <= w_issue;
      if (w_accept) begin
        r_cnt        <= '0;
        r_phase      <= '0;
        r_best_tt    <= io_bus.in_tt;
        r_best_phase <= '0;
        for (int j = 0; j < NUM_INPUTS; j++) begin
          r_perm[j]      <= PW'(j);
          r_c[j]         <= '0;
          r_best_perm[j] <= PW'(j);
        end
`ifdef NPN_OUT_NEG_EN
        r_best_neg   <= 1'b0;
`endif
      end else begin
        if (r_state == S_RUN) r_cnt <= r_cnt + 1'b1;
        if (w_issue) begin
          if (&r_phase) begin
            r_phase <= '0;
            r_perm  <= w_perm_nx;
            r_c     <= w_c_nx;
          end else begin
            r_phase <= r_phase + 1'b1;
          end
        end
        if (r_vld_p1 && w_win) begin
          r_best_tt    <= w_win_tt;
          r_best_phase <= r_phase_p1;
          r_best_perm  <= r_perm_p1;
`ifdef NPN_OUT_NEG_EN
          r_best_neg   <= w_win_neg;
`endif
        end
      end
    end
  end

  always_comb begin
    w_out_perm = '0;
    for (int j = 0; j < NUM_INPUTS; j++) w_out_perm[j*PW +: PW] = r_best_perm[j];
  end

  assign io_bus.in_ready  = w_in_ready;
  assign io_bus.out_valid = w_out_valid;
  assign io_bus.out_tt    = r_best_tt;
  assign io_bus.out_phase = r_best_phase;
  assign io_bus.out_perm  = w_out_perm;
`ifdef NPN_OUT_NEG_EN
  assign io_bus.out_neg   = r_best_neg;
`else
  assign io_bus.out_neg   = 1'b0;
`endif

endmodule
